mem_wb: RTL and testbench



---
 rtl/mem_wb_pkg.sv | 28 ++
 rtl/mem_wb.sv | 93 +++++++++
 tb/tb_mem_wb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb shared types and constants
// state encodings, bus widths, helpers
package mem_wb_pkg;

  localparam int DATA_BUS = 32;
  localparam int REG_BUS  = 5;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  localparam logic [REG_BUS-1:0]  REG_X0    = '0;
  localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

  typedef enum logic [1:0] {
    MEMWB_IDLE = 2'd0,
    MEMWB_REQ  = 2'd1,
    MEMWB_WB   = 2'd2
  } memwb_state_t;

  function automatic logic [DATA_BUS-1:0] word_align(
    input logic [DATA_BUS-1:0] a
  );
    return {a[DATA_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb.sv
// mem_wb: memory access + write-back stage
// word loads/stores over req/ack bus
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ena_i,
  input  logic                mem_rw_i,
  input  logic [DATA_BUS-1:0] mem_addr_i,
  input  logic [DATA_BUS-1:0] mem_data_i,
  input  logic [REG_BUS-1:0]  gprs_waddr_i,
  input  logic [DATA_BUS-1:0] gprs_wdata_i,
  output logic                stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [DATA_BUS-1:0] dmem_addr_o,
  output logic [DATA_BUS-1:0] dmem_wdata_o,
  input  logic                dmem_ack_i,
  input  logic [DATA_BUS-1:0] dmem_rdata_i,
  output logic                gprs_we_o,
  output logic [REG_BUS-1:0]  gprs_waddr_o,
  output logic [DATA_BUS-1:0] gprs_wdata_o
);

  memwb_state_t        state;
  logic                rw_q;
  logic [DATA_BUS-1:0] addr_q;
  logic [DATA_BUS-1:0] data_q;
  logic [REG_BUS-1:0]  waddr_q;
  logic                in_req;

  assign in_req = (state == MEMWB_REQ);

  // FSM, operation latches and registered write-back port
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MEMWB_IDLE;
      rw_q         <= MEM_READ;
      addr_q       <= DATA_ZERO;
      data_q       <= DATA_ZERO;
      waddr_q      <= REG_X0;
      gprs_we_o    <= DISABLE;
      gprs_waddr_o <= REG_X0;
      gprs_wdata_o <= DATA_ZERO;
    end else begin
      unique case (state)
        MEMWB_IDLE, MEMWB_WB: begin
          if (mem_ena_i) begin
            state     <= MEMWB_REQ;
            rw_q      <= mem_rw_i;
            addr_q    <= word_align(mem_addr_i);
            data_q    <= mem_data_i;
            waddr_q   <= gprs_waddr_i;
            gprs_we_o <= DISABLE;
          end else begin
            state        <= MEMWB_IDLE;
            gprs_we_o    <= (gprs_waddr_i != REG_X0);
            gprs_waddr_o <= gprs_waddr_i;
            gprs_wdata_o <= gprs_wdata_i;
          end
        end
        MEMWB_REQ: begin
          gprs_we_o <= DISABLE;
          if (dmem_ack_i) begin
            if (rw_q == MEM_READ) begin
              state        <= MEMWB_WB;
              gprs_we_o    <= (waddr_q != REG_X0);
              gprs_waddr_o <= waddr_q;
              gprs_wdata_o <= dmem_rdata_i;
            end else begin
              state <= MEMWB_IDLE;
            end
          end
        end
        default: begin
          state     <= MEMWB_IDLE;
          gprs_we_o <= DISABLE;
        end
      endcase
    end
  end

  // bus and stall decode from registered state only
  always_comb begin
    stall_o      = in_req;
    dmem_req_o   = in_req;
    dmem_we_o    = in_req & (rw_q == MEM_WRITE);
    dmem_addr_o  = addr_q;
    dmem_wdata_o = data_q;
  end

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: scoreboard bench for mem_wb
// directed ops, queued expectations
module tb_mem_wb;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } bexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ena_i = 1'b0;
  logic        mem_rw_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [4:0]  gprs_waddr_i = '0;
  logic [31:0] gprs_wdata_i = '0;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        gprs_we_o;
  logic [4:0]  gprs_waddr_o;
  logic [31:0] gprs_wdata_o;

  int vectors = 0;
  int miscompares = 0;

  gexp_t gq[$];
  bexp_t bq[$];
  int    sq[$];

  logic bus_auto = 1'b1;
  int   cyc = 0;
  int   last_gap = -1;

  mem_wb dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ena_i    (mem_ena_i),
    .mem_rw_i     (mem_rw_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .gprs_waddr_i (gprs_waddr_i),
    .gprs_wdata_i (gprs_wdata_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .gprs_we_o    (gprs_we_o),
    .gprs_waddr_o (gprs_waddr_o),
    .gprs_wdata_o (gprs_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // write-back monitor
  initial begin
    gexp_t e;
    forever begin
      @(negedge clk);
      if (gprs_we_o === 1'b1) begin
        if (gq.size() == 0) begin
          chk("gprs_unexpected_we", 32'(gprs_waddr_o), 32'hFFFF_FFFF);
        end else begin
          e = gq.pop_front();
          chk("gprs_waddr", 32'(gprs_waddr_o), 32'(e.waddr));
          chk("gprs_wdata", gprs_wdata_o, e.wdata);
        end
      end
    end
  end

  // stall run-length monitor
  initial begin
    int run = 0;
    forever begin
      @(negedge clk);
      if (stall_o === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sq.size() == 0) chk("stall_unexpected", run, 0);
        else chk("stall_len", run, sq.pop_front());
        run = 0;
      end
    end
  end

  // bus model: request checker and acker
  initial begin
    bexp_t cur;
    logic  prev_req = 1'b0;
    logic  prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    int    cnt = 0;
    int    last_req_cyc = 0;
    cur = '{1'b0, 32'h0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (dmem_req_o === 1'b1) begin
        if (!prev_req || prev_ack) begin
          last_gap = cyc - last_req_cyc - 1;
          cnt = 0;
          if (bq.size() == 0) begin
            chk("bus_unexpected_req", dmem_addr_o, 32'hFFFF_FFFF);
          end else begin
            cur = bq.pop_front();
            chk("bus_we", 32'(dmem_we_o), 32'(cur.we));
            chk("bus_addr", dmem_addr_o, cur.addr);
            if (cur.we) chk("bus_wdata", dmem_wdata_o, cur.wdata);
          end
        end else begin
          chk("bus_addr_stable", dmem_addr_o, prev_addr);
        end
        last_req_cyc = cyc;
      end
      if (bus_auto) begin
        if (dmem_req_o === 1'b1 && cnt == cur.waits) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = cur.rdata;
        end else begin
          dmem_ack_i   = 1'b0;
          dmem_rdata_i = $urandom;
        end
        if (dmem_req_o === 1'b1) cnt++;
      end
      prev_ack  = dmem_ack_i;
      prev_req  = (dmem_req_o === 1'b1);
      prev_addr = dmem_addr_o;
    end
  end

  task automatic op(input logic ena, input logic rw,
                    input logic [31:0] addr,
                    input logic [31:0] data,
                    input logic [4:0] wa,
                    input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (stall_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("stall_timeout", 32'(stall_o), 32'h0);
    mem_ena_i    = ena;
    mem_rw_i     = rw;
    mem_addr_i   = addr;
    mem_data_i   = data;
    gprs_waddr_i = wa;
    gprs_wdata_i = wd;
    @(posedge clk);
    #1;
    mem_ena_i    = 1'b0;
    gprs_waddr_i = '0;
    gprs_wdata_i = $urandom;
    mem_addr_i   = $urandom;
    mem_data_i   = $urandom;
  endtask

  task automatic alu(input logic [4:0] wa, input logic [31:0] wd);
    if (wa != 5'd0) gq.push_back('{wa, wd});
    op(1'b0, 1'b0, 32'h0, 32'h0, wa, wd);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] wa,
                      input logic [31:0] rd, input int waits,
                      input logic [31:0] aligned);
    bq.push_back('{1'b0, aligned, 32'h0, rd, waits});
    sq.push_back(waits + 1);
    if (wa != 5'd0) gq.push_back('{wa, rd});
    op(1'b1, 1'b0, addr, 32'h0, wa, 32'h0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] d,
                       input int waits, input logic [31:0] aligned);
    bq.push_back('{1'b1, aligned, d, 32'h0, waits});
    sq.push_back(waits + 1);
    op(1'b1, 1'b1, addr, d, 5'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ena_i    = 1'($urandom);
      mem_rw_i     = 1'($urandom);
      mem_addr_i   = $urandom;
      mem_data_i   = $urandom;
      gprs_waddr_i = 5'($urandom);
      gprs_wdata_i = $urandom;
      dmem_ack_i   = 1'b0;
    end
    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    chk("rst_we", 32'(dmem_we_o), 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_gwe", 32'(gprs_we_o), 32'h0);
    chk("rst_gwaddr", 32'(gprs_waddr_o), 32'h0);
    chk("rst_gwdata", gprs_wdata_o, 32'h0);
    rst          = 1'b0;
    mem_ena_i    = 1'b0;
    gprs_waddr_i = 5'd5;
    gprs_wdata_i = 32'h1234;
    gq.push_back('{5'd5, 32'h1234});
    @(posedge clk);
    #1;
    gprs_waddr_i = 5'd0;
    @(negedge clk);
    chk("alu_no_stall", 32'(stall_o), 32'h0);

    alu(5'd0, 32'h1234);
    alu(5'd31, 32'hCAFE_0001);

    load(32'h103, 5'd7, 32'hDEAD_BEEF, 3, 32'h100);
    store(32'h200, 32'hA5A5_A5A5, 0, 32'h200);
    store(32'h2F3, 32'h0BAD_F00D, 2, 32'h2F0);
    load(32'h80, 5'd0, 32'h7777_7777, 1, 32'h80);

    load(32'h40, 5'd3, 32'h1111_1111, 0, 32'h40);
    load(32'h44, 5'd4, 32'h2222_2222, 1, 32'h44);
    @(negedge clk);
    #1;
    chk("b2b_gap", last_gap, 1);

    load(32'h50, 5'd6, 32'h3333_3333, 0, 32'h50);
    alu(5'd9, 32'h0000_0099);

    bus_auto = 1'b0;
    bq.push_back('{1'b0, 32'h300, 32'h0, 32'h0, 0});
    sq.push_back(1);
    op(1'b1, 1'b0, 32'h301, 32'h0, 5'd9, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstreq_req", 32'(dmem_req_o), 32'h0);
    chk("rstreq_stall", 32'(stall_o), 32'h0);
    rst          = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    chk("late_ack_gwe", 32'(gprs_we_o), 32'h0);
    chk("late_ack_req", 32'(dmem_req_o), 32'h0);
    dmem_ack_i = 1'b0;
    bus_auto   = 1'b1;

    alu(5'd12, 32'h0000_0C0C);

    repeat (10) @(negedge clk);
    chk("gq_drained", gq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("sq_drained", sq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
